scytale_encryption: RTL and testbench
=====================================

# scytale_encryption

Scytale cipher encoder, the transmit-side counterpart of the scytale decryption path. Collects plaintext bytes until an end token, then emits them in transposed (column-major) order using a key_N-row by key_M-column matrix. Sits on the same 8-bit system-clock data interface as the decryption engines and is used to generate ciphertext for loopback testing and for the encrypting side of the link.

## Interface
- MAX_LEN, 50: plaintext buffer depth in bytes
- D_WIDTH, 8: character width
- KEY_WIDTH, 8: width of each key field
- clk  input  1  system clock; one clock; all state on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- data_i  input  D_WIDTH  plaintext character
- valid_i  input  1  data_i qualifier, one character per cycle
- key_M  input  KEY_WIDTH  column count; latched on token acceptance
- key_N  input  KEY_WIDTH  row count; latched on token acceptance
- busy  output  1  emission in progress; inputs are ignored while high
- data_o  output  D_WIDTH  ciphertext character, registered
- valid_o  output  1  data_o qualifier, registered

## Operation
- Encryption rule: plaintext p is written row-major into an N×M matrix. Ciphertext is read column-major: c[j*N+i] = p[i*M+j], for i<N and j<M. Emission length is L = M*N.
- FSM states:
  - COLLECT (reset state)
  - EMIT
- COLLECT:
  - valid_i with data_i != END_TOKEN (0xFA): store the byte at wr_cnt, then increment wr_cnt.
  - When wr_cnt == MAX_LEN, further characters are dropped and wr_cnt saturates.
- Token acceptance (valid_i with data_i == END_TOKEN, in COLLECT):
  - Latch key_M and key_N.
  - If wr_cnt == 0, key_M == 0 or key_N == 0: stay in COLLECT, clear wr_cnt, no output.
  - Otherwise go to EMIT.
- EMIT:
  - Each cycle, read buffer address a, then advance the counters.
  - Counters reset to i=0, j=0, a=0. Each step does i++, a += M.
  - When i == N-1: i=0, j++, a = j+1.
  - No multiplier is used. a is 16 bits; the maximum value is N*M-1.
- Positions with a >= wr_cnt or a >= MAX_LEN are short-message positions; see Configuration.
- After the L-th position, clear wr_cnt and return to COLLECT.
- valid_i is ignored in EMIT, including tokens.
- busy = (state == EMIT), registered.

## Timing
- Reset values: data_o = 0x00, valid_o = 0, busy = 0, state = COLLECT, wr_cnt = 0.
- Token sampled at edge T: busy = 1 from T+1.
- First valid_o is in the cycle after edge T+1. The k-th output follows edge T+k.
- The last output follows edge T+L. busy and valid_o fall together at edge T+L+1.
- busy is high for exactly L+1 cycles.
- A new plaintext character is accepted in the first cycle busy is low.
- valid_o is high for a single cycle per character. The same byte is never held for two cycles.
- Reset asserted mid-EMIT: all outputs go to reset values immediately, and the buffered message is discarded.

## Configuration
- SCYTALE_ENC_PAD_EN defined:
  - Short-message positions output PAD_CHAR (0x20) with valid_o = 1.
  - Ciphertext length is always L.
- SCYTALE_ENC_PAD_EN undefined:
  - Short-message positions produce a cycle with valid_o = 0, and data_o holds its previous value.
  - The iteration still takes L cycles, so busy timing is identical in both builds.

## Structure
- Shared package (cipher_pkg):
  - END_TOKEN = 8'hFA
  - PAD_CHAR = 8'h20
  - FSM state typedef {COLLECT, EMIT}
  - Address width constant (16)
- One sub-module, scytale_index_gen:
  - Inputs: start, step, key_M, key_N.
  - Outputs: addr, last.
  - Holds the i/j/a counters. The encoder keeps the buffer, FSM and output registers.

## Test plan
- M=3, N=2; send "ABCDEF" then 0xFA:
  - Output "ADBECF" on 6 consecutive valid_o cycles.
  - busy high for 7 cycles.
- M=3, N=2; send "ABCD" then 0xFA:
  - With PAD_EN, output A,D,B,0x20,C,0x20.
  - Without PAD_EN, output A,D,B,C, with valid_o low at positions 4 and 6.
- Send 0xFA with no characters, or with key_M=0 and "AB":
  - No valid_o and busy stays 0.
  - The next message "XY" with M=2, N=1 outputs "XY".
- Send 52 characters, then a token with M=10, N=5:
  - The 51st and 52nd characters are dropped.
  - 50 outputs are produced, the first three being p[0], p[10], p[20].
- M=2, N=2, "WXYZ": drive valid_i with 'Q' and 0xFA during EMIT:
  - Output is "WYXZ", unaffected.
  - The block returns to COLLECT with wr_cnt = 0.
- Assert rst_n low after the 2nd output of a 6-byte message:
  - busy, valid_o and data_o go to 0 immediately.
  - After reset release, "ABCDEF" with M=3, N=2 outputs "ADBECF".

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared constants and types for the scytale cipher blocks.
package cipher_pkg;

    localparam logic [7:0] END_TOKEN = 8'hFA;
    localparam logic [7:0] PAD_CHAR  = 8'h20;
    localparam int         ADDR_W    = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/scytale_index_gen.sv
// Column-major read address generator for the scytale encoder.
// Walks an N x M matrix by repeated addition, so no multiplier is needed.
module scytale_index_gen
    import cipher_pkg::*;
#(
    parameter int KEY_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [KEY_WIDTH-1:0] key_M,
    input  logic [KEY_WIDTH-1:0] key_N,
    output logic [ADDR_W-1:0]    addr,
    output logic                 last
);

    logic [KEY_WIDTH-1:0] i;
    logic [KEY_WIDTH-1:0] j;
    logic [ADDR_W-1:0]    a;
    logic                 row_end;

    assign row_end = (i == key_N - KEY_WIDTH'(1));
    assign last    = row_end && (j == key_M - KEY_WIDTH'(1));
    assign addr    = a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
            a <= '0;
        end else if (start) begin
            i <= '0;
            j <= '0;
            a <= '0;
        end else if (step) begin
            if (row_end) begin
                // Next column starts at the flat index equal to the new column number.
                i <= '0;
                j <= j + KEY_WIDTH'(1);
                a <= ADDR_W'(j) + ADDR_W'(1);
            end else begin
                i <= i + KEY_WIDTH'(1);
                a <= a + ADDR_W'(key_M);
            end
        end
    end

endmodule

// File: rtl/scytale_encryption.sv
// Scytale cipher encoder: buffers plaintext until END_TOKEN, then emits it column-major.
// Build option SCYTALE_ENC_PAD_EN: pad short-message positions with PAD_CHAR instead of gaps.
module scytale_encryption
    import cipher_pkg::*;
#(
    parameter int MAX_LEN   = 50,
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_M,
    input  logic [KEY_WIDTH-1:0] key_N,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int BUF_W = $clog2(MAX_LEN);

    state_t               state;
    logic [CNT_W-1:0]     wr_cnt;
    logic [KEY_WIDTH-1:0] m_q;
    logic [KEY_WIDTH-1:0] n_q;
    logic                 done;
    logic [D_WIDTH-1:0]   mem [MAX_LEN];
    logic [ADDR_W-1:0]    addr;
    logic                 last;
    logic                 is_token;
    logic                 token;
    logic                 store;
    logic                 step;
    logic                 in_range;

    assign is_token = (data_i == D_WIDTH'(END_TOKEN));
    assign token    = (state == COLLECT) && valid_i && is_token;
    assign store    = (state == COLLECT) && valid_i && !is_token && (wr_cnt < CNT_W'(MAX_LEN));
    assign step     = (state == EMIT) && !done;
    assign in_range = (addr < ADDR_W'(wr_cnt)) && (addr < ADDR_W'(MAX_LEN));

    scytale_index_gen #(
        .KEY_WIDTH (KEY_WIDTH)
    ) u_index_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (token),
        .step  (step),
        .key_M (m_q),
        .key_N (n_q),
        .addr  (addr),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_cnt[BUF_W-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            wr_cnt  <= '0;
            m_q     <= '0;
            n_q     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    valid_o <= 1'b0;
                    if (token) begin
                        m_q <= key_M;
                        n_q <= key_N;
                        if (wr_cnt == '0 || key_M == '0 || key_N == '0) begin
                            wr_cnt <= '0;
                        end else begin
                            state <= EMIT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else if (store) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    end
                end
                EMIT: begin
                    // One extra cycle after the last position keeps busy up for L+1 cycles.
                    if (done) begin
                        state   <= COLLECT;
                        busy    <= 1'b0;
                        valid_o <= 1'b0;
                        wr_cnt  <= '0;
                        done    <= 1'b0;
                    end else begin
                        if (last) begin
                            done <= 1'b1;
                        end
                        if (in_range) begin
                            data_o  <= mem[addr[BUF_W-1:0]];
                            valid_o <= 1'b1;
                        end else begin
`ifdef SCYTALE_ENC_PAD_EN
                            data_o  <= D_WIDTH'(PAD_CHAR);
                            valid_o <= 1'b1;
`else
                            valid_o <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_scytale_encryption.sv
// Scoreboard bench for scytale_encryption with a division-based reference model.
module tb_scytale_encryption;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic [7:0] key_M = '0;
    logic [7:0] key_N = '0;
    logic       busy;
    logic [7:0] data_o;
    logic       valid_o;

    scytale_encryption #(
        .MAX_LEN   (50),
        .D_WIDTH   (8),
        .KEY_WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key_M   (key_M),
        .key_N   (key_N),
        .busy    (busy),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        int         pos;
    } exp_t;

    exp_t exp_q[$];
    int   busy_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   busy_cyc = 0;
    exp_t mon_e;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
        return q;
    endfunction

    function automatic bq_t rand_msg(input int len);
        bq_t q;
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hFA) b = 8'h41;
            q.push_back(b);
        end
        return q;
    endfunction

    // Reference: ciphertext position k reads plaintext cell (row k%N, column k/N).
    task automatic model(input bq_t msg, input int m, input int n);
        int len;
        int idx;
        exp_t e;
        len = (msg.size() > 50) ? 50 : msg.size();
        if (len == 0 || m == 0 || n == 0) return;
        for (int k = 0; k < m * n; k++) begin
            idx = (k % n) * m + (k / n);
            e.pos = k + 1;
            if (idx < len) begin
                e.d = msg[idx];
                exp_q.push_back(e);
            end else begin
`ifdef SCYTALE_ENC_PAD_EN
                e.d = 8'h20;
                exp_q.push_back(e);
`endif
            end
        end
        busy_q.push_back(m * n + 1);
    endtask

    // Monitor: pops expected characters and checks their cycle slot and busy length.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cyc = 0;
        end else begin
            if (busy) busy_cyc++;
            if (valid_o) begin
                chk("valid_without_busy", busy, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data_o", data_o, mon_e.d);
                    chk("output_slot", busy_cyc - 1, mon_e.pos);
                end
            end
            if (!busy && busy_cyc != 0) begin
                if (busy_q.size() == 0) chk("unexpected_busy", busy_cyc, 0);
                else chk("busy_length", busy_cyc, busy_q.pop_front());
                busy_cyc = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 in the first cycle busy is low.
    task automatic send_msg(input bq_t msg, input int m, input int n, input bit inject);
        bit emit;
        int cyc;
        emit = (msg.size() != 0) && (m != 0) && (n != 0);
        model(msg, m, n);
        foreach (msg[k]) begin
            data_i  = msg[k];
            valid_i = 1'b1;
            key_M   = 8'($urandom_range(0, 255));
            key_N   = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        data_i  = 8'hFA;
        valid_i = 1'b1;
        key_M   = 8'(m);
        key_N   = 8'(n);
        @(posedge clk); #1;
        valid_i = 1'b0;
        if (emit) begin
            chk("busy_after_token", busy, 1);
            for (cyc = 0; cyc < 400 && busy; cyc++) begin
                if (inject) begin
                    valid_i = 1'b1;
                    data_i  = (cyc % 2 == 0) ? 8'h51 : 8'hFA;
                    key_M   = 8'($urandom_range(1, 9));
                    key_N   = 8'($urandom_range(1, 9));
                end
                @(posedge clk); #1;
            end
            valid_i = 1'b0;
            if (busy) chk("busy_timeout", 1, 0);
            chk("outputs_pending", exp_q.size(), 0);
        end else begin
            repeat (3) begin
                chk("busy_idle", busy, 0);
                chk("valid_idle", valid_o, 0);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        bq_t msg;
        int  cnt;
        int  m;
        int  n;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid_o", valid_o, 0);
        chk("reset_data_o", data_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_msg(str2q("ABCDEF"), 3, 2, 1'b0);
        send_msg(str2q("ABCD"), 3, 2, 1'b0);
        msg = {};
        send_msg(msg, 3, 2, 1'b0);
        send_msg(str2q("AB"), 0, 2, 1'b0);
        send_msg(str2q("XY"), 2, 1, 1'b0);
        send_msg(rand_msg(52), 10, 5, 1'b0);
        send_msg(str2q("WXYZ"), 2, 2, 1'b1);
        send_msg(str2q("XY"), 2, 1, 1'b0);

        // Abort an emission with reset after its second character.
        msg = str2q("ABCDEF");
        model(msg, 3, 2);
        foreach (msg[k]) begin
            data_i = msg[k]; valid_i = 1'b1;
            @(posedge clk); #1;
        end
        data_i = 8'hFA; key_M = 8'd3; key_N = 8'd2;
        @(posedge clk); #1;
        valid_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            @(posedge clk); #1;
            if (valid_o) cnt++;
        end
        chk("reset_test_outputs_seen", cnt, 2);
        rst_n = 1'b0;
        exp_q.delete();
        busy_q.delete();
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_valid_o", valid_o, 0);
        chk("midreset_data_o", data_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_msg(str2q("ABCDEF"), 3, 2, 1'b0);

        for (int t = 0; t < 30; t++) begin
            m = (t % 7 == 3) ? 0 : $urandom_range(1, 8);
            n = (t % 11 == 5) ? 0 : $urandom_range(1, 8);
            send_msg(rand_msg($urandom_range(0, 55)), m, n, (t % 3 == 0));
        end

        repeat (4) @(posedge clk);
        chk("final_exp_queue", exp_q.size(), 0);
        chk("final_busy_queue", busy_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
